// File: rtl/usr_ap_ctrl_pkg.sv
// Shared definitions for the ap_ctrl_hs launcher: FSM state encoding and widths.
// The state encoding matches the one the timing/watch monitor decodes.
package usr_ap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } ap_state_t;

    localparam int PEND_W = 4;
    localparam int CNT_W  = 32;

endpackage

// File: rtl/usr_ap_ctrl.sv
// ap_ctrl_hs launcher: merges VIO/host start pulses into a saturating request queue,
// runs the core handshake, and keeps launch/completion/drop counters plus a run watchdog.
module usr_ap_ctrl
    import usr_ap_ctrl_pkg::*;
#(
    parameter int unsigned PEND_MAX    = 4,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              vio_ap_start,
    input  logic              pc_ap_start,
    input  logic              core_ap_ready,
    input  logic              core_ap_done,
    input  logic              core_ap_idle,
    input  logic              cnt_clr,
    output logic              ap_start,
    output logic              done_pulse,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic [CNT_W-1:0]  start_cnt,
    output logic [CNT_W-1:0]  done_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              err_timeout
);

    localparam logic [PEND_W:0] PMAX = 5'(PEND_MAX);

    ap_state_t         r_state;
    ap_state_t         w_state_nxt;
    logic              w_take;
    logic              w_accept;
    logic [PEND_W-1:0] r_pend;
    logic [CNT_W-1:0]  r_start_cnt;
    logic [CNT_W-1:0]  r_done_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic [31:0]       r_run_cyc;
    logic              r_err;
    logic [1:0]        w_req;
    logic [PEND_W:0]   w_pend_sum;
    logic [PEND_W:0]   w_excess;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              w_running;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != '0 && core_ap_idle) begin
                    w_state_nxt = ST_START;
                    w_take      = 1'b1;
                end
            end
            ST_START: begin
                // ready and done together skip RUN entirely
                if (core_ap_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = core_ap_done ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_ap_done) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Both sources in one cycle are two requests; overflow beyond PEND_MAX is dropped.
    always_comb begin
        w_req      = {1'b0, vio_ap_start} + {1'b0, pc_ap_start};
        w_pend_sum = {1'b0, r_pend} + {3'b0, w_req} - {4'b0, w_take};
        if (w_pend_sum > PMAX) begin
            w_excess   = w_pend_sum - PMAX;
            w_pend_nxt = PMAX[PEND_W-1:0];
        end else begin
            w_excess   = '0;
            w_pend_nxt = w_pend_sum[PEND_W-1:0];
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_pend <= '0;
        else        r_pend <= w_pend_nxt;
    end

    assign w_running = (r_state == ST_START) || (r_state == ST_RUN);

    // Watchdog only flags; the core owns completion so the FSM keeps waiting.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_run_cyc <= '0;
        end else if (w_take) begin
            r_run_cyc <= '0;
        end else if (w_running) begin
            r_run_cyc <= r_run_cyc + 32'd1;
        end
    end

    // cnt_clr wins over any same-cycle increment
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_start_cnt <= '0;
            r_done_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_err       <= 1'b0;
        end else if (cnt_clr) begin
            r_start_cnt <= '0;
            r_done_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept)               r_start_cnt <= r_start_cnt + 32'd1;
            if (r_state == ST_DONE)     r_done_cnt  <= r_done_cnt + 32'd1;
            r_drop_cnt <= r_drop_cnt + {27'd0, w_excess};
            if (w_running && r_run_cyc == TIMEOUT_CYC) r_err <= 1'b1;
        end
    end

    assign ap_start    = (r_state == ST_START);
    assign done_pulse  = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign pend_cnt    = r_pend;
    assign start_cnt   = r_start_cnt;
    assign done_cnt    = r_done_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_usr_ap_ctrl.sv
// Bench for usr_ap_ctrl: a behavioural core model answers the handshake and a
// transaction scoreboard (requests = launches + drops + pending) checks the launcher.
module tb_usr_ap_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        vio_ap_start, pc_ap_start;
    logic        core_ap_ready, core_ap_done, core_ap_idle;
    logic        cnt_clr;
    logic        ap_start, done_pulse, busy;
    logic [3:0]  pend_cnt;
    logic [31:0] start_cnt, done_cnt, drop_cnt;
    logic        err_timeout;

    logic r_done_m;
    logic spur;
    assign core_ap_done = r_done_m | spur;

    int checks = 0, failures = 0;
    int n_req = 0, n_launch = 0, n_ready = 0, n_done = 0, n_pulse = 0, n_hi = 0;
    int ready_dly = 3, done_dly = 50;
    bit same_cyc = 0, hang = 0;
    int rcnt = 0, dcnt = 0;
    bit dwait = 0;

    always #5 ap_clk = ~ap_clk;

    usr_ap_ctrl #(.PEND_MAX(4), .TIMEOUT_CYC(32'd100)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .vio_ap_start(vio_ap_start), .pc_ap_start(pc_ap_start),
        .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done),
        .core_ap_idle(core_ap_idle), .cnt_clr(cnt_clr),
        .ap_start(ap_start), .done_pulse(done_pulse), .busy(busy),
        .pend_cnt(pend_cnt), .start_cnt(start_cnt), .done_cnt(done_cnt),
        .drop_cnt(drop_cnt), .err_timeout(err_timeout)
    );

    // Core model: accepts after ready_dly cycles of ap_start, finishes done_dly cycles later.
    initial begin
        core_ap_ready = 1'b0;
        r_done_m      = 1'b0;
        core_ap_idle  = 1'b1;
        forever begin
            @(posedge ap_clk);
            #1;
            core_ap_ready = 1'b0;
            r_done_m      = 1'b0;
            if (ap_rst) begin
                rcnt  = 0;
                dwait = 0;
            end else begin
                if (done_pulse) n_pulse++;
                if (ap_start) begin
                    if (rcnt == 0) n_launch++;
                    n_hi++;
                    rcnt++;
                    if (rcnt >= ready_dly) begin
                        core_ap_ready = 1'b1;
                        n_ready++;
                        rcnt = 0;
                        if (same_cyc) begin
                            r_done_m = 1'b1;
                            n_done++;
                        end else begin
                            dwait = 1;
                            dcnt  = 0;
                        end
                    end
                end else if (dwait) begin
                    dcnt++;
                    if (!hang && dcnt >= done_dly) begin
                        r_done_m = 1'b1;
                        n_done++;
                        dwait = 0;
                    end
                end
            end
            core_ap_idle = !dwait;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic req(input logic v, input logic p);
        vio_ap_start = v;
        pc_ap_start  = p;
        n_req += int'(v) + int'(p);
        tick();
        vio_ap_start = 1'b0;
        pc_ap_start  = 1'b0;
    endtask

    task automatic drain(input int lim);
        int k;
        k = 0;
        while ((busy || pend_cnt != 4'd0 || !core_ap_idle) && k < lim) begin
            tick();
            k++;
        end
        chk("drain_bound", 32'(k < lim), 32'd1);
    endtask

    initial begin
        int h0, p0, l0, r0, d0, q0;
        vio_ap_start = 1'b0;
        pc_ap_start  = 1'b0;
        cnt_clr      = 1'b0;
        spur         = 1'b0;
        ap_rst       = 1'b1;
        repeat (3) tick();
        chk("rst_ap_start", 32'(ap_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_outs", {pend_cnt, 25'd0, done_pulse, err_timeout, 1'b0},  32'd0);
        chk("rst_cnts", start_cnt | done_cnt | drop_cnt, 32'd0);
        ap_rst = 1'b0;
        tick();

        // 1: single request, ready on 3rd cycle of ap_start, done 50 later
        h0 = n_hi; p0 = n_pulse;
        req(1'b1, 1'b0);
        chk("t1_pend", 32'(pend_cnt), 32'd1);
        chk("t1_start_lat1", 32'(ap_start), 32'd0);
        tick();
        chk("t1_start_lat2", 32'(ap_start), 32'd1);
        chk("t1_pend_taken", 32'(pend_cnt), 32'd0);
        drain(200);
        chk("t1_start_cnt", start_cnt, 32'd1);
        chk("t1_done_cnt", done_cnt, 32'd1);
        chk("t1_hi_cycles", 32'(n_hi - h0), 32'd3);
        chk("t1_pulses", 32'(n_pulse - p0), 32'd1);

        // 2: both sources in one cycle
        ready_dly = 1; done_dly = 5; l0 = n_launch;
        req(1'b1, 1'b1);
        chk("t2_pend", 32'(pend_cnt), 32'd2);
        drain(200);
        chk("t2_launches", 32'(n_launch - l0), 32'd2);
        chk("t2_done_cnt", done_cnt, 32'd3);
        chk("t2_drop", drop_cnt, 32'd0);

        // 3: six requests while busy saturate the queue at 4
        done_dly = 40; l0 = n_launch;
        req(1'b1, 1'b0);
        tick();
        tick();
        chk("t3_running", 32'(busy), 32'd1);
        req(1'b1, 1'b1);
        chk("t3_pend2", 32'(pend_cnt), 32'd2);
        req(1'b1, 1'b1);
        req(1'b1, 1'b1);
        chk("t3_pend_sat", 32'(pend_cnt), 32'd4);
        chk("t3_drop", drop_cnt, 32'd2);
        done_dly = 3;
        drain(1000);
        chk("t3_launches", 32'(n_launch - l0), 32'd5);
        chk("t3_start_cnt", start_cnt, 32'd8);
        chk("t3_done_cnt", done_cnt, 32'd8);

        // spurious done while idle is ignored
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_pulse", 32'(done_pulse), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        tick();
        chk("spur_done_cnt", done_cnt, 32'd8);

        // 4: ready and done in the same cycle
        same_cyc = 1; ready_dly = 1;
        req(1'b0, 1'b1);
        tick();
        chk("t4_start", 32'(ap_start), 32'd1);
        tick();
        chk("t4_pulse", 32'(done_pulse), 32'd1);
        chk("t4_start_cnt", start_cnt, 32'd9);
        tick();
        chk("t4_pulse_end", 32'(done_pulse), 32'd0);
        chk("t4_done_cnt", done_cnt, 32'd9);
        same_cyc = 0;

        // random traffic against the conservation scoreboard
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnts", start_cnt | done_cnt | drop_cnt, 32'd0);
        l0 = n_launch; r0 = n_ready; d0 = n_done; q0 = n_req; p0 = n_pulse;
        for (int i = 0; i < 300; i++) begin
            vio_ap_start = ($urandom_range(0, 5) == 0);
            pc_ap_start  = ($urandom_range(0, 5) == 0);
            n_req += int'(vio_ap_start) + int'(pc_ap_start);
            ready_dly = int'($urandom_range(1, 4));
            done_dly  = int'($urandom_range(1, 30));
            tick();
            chk("rnd_pend_max", 32'(pend_cnt <= 4'd4), 32'd1);
            chk("rnd_conserve", 32'(n_launch - l0) + drop_cnt + 32'(pend_cnt), 32'(n_req - q0));
        end
        vio_ap_start = 1'b0;
        pc_ap_start  = 1'b0;
        drain(3000);
        chk("rnd_start_cnt", start_cnt, 32'(n_ready - r0));
        chk("rnd_done_cnt", done_cnt, 32'(n_done - d0));
        chk("rnd_pulses", 32'(n_pulse - p0), 32'(n_done - d0));
        chk("rnd_drop", drop_cnt, 32'((n_req - q0) - (n_launch - l0)));
        chk("rnd_no_timeout", 32'(err_timeout), 32'd0);

        // 5: core never completes, watchdog at 100 cycles
        hang = 1; ready_dly = 1;
        req(1'b1, 1'b0);
        tick();
        chk("t5_start", 32'(ap_start), 32'd1);
        repeat (100) tick();
        chk("t5_err_early", 32'(err_timeout), 32'd0);
        tick();
        chk("t5_err_set", 32'(err_timeout), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_run_no_start", 32'(ap_start), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5_err_clr", 32'(err_timeout), 32'd0);
        chk("t5_cnts_clr", start_cnt | done_cnt | drop_cnt, 32'd0);
        tick();
        chk("t5_err_stays", 32'(err_timeout), 32'd0);
        chk("t5_still_run", 32'(busy), 32'd1);

        // 6: reset mid-run with three pending
        req(1'b1, 1'b1);
        req(1'b1, 1'b0);
        chk("t6_pend", 32'(pend_cnt), 32'd3);
        ap_rst = 1'b1;
        #1;
        chk("t6_rst_start", 32'(ap_start), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_pend", 32'(pend_cnt), 32'd0);
        chk("t6_rst_flags", {30'd0, done_pulse, err_timeout}, 32'd0);
        tick();
        ap_rst = 1'b0;
        hang = 0;
        l0 = n_launch;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_launch", 32'(ap_start), 32'd0);
        end
        chk("t6_launches", 32'(n_launch - l0), 32'd0);
        chk("t6_pend_after", 32'(pend_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
